// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
//   Oversampling UART receiver (8N1, LSB first). The serial input is brought
//   into the clock domain by a 2-FF synchroniser. Start detection, mid-bit
//   sampling and stop checking advance only on cycles where the oversample
//   tick i_rxen is high (OSR ticks per bit). Each correctly framed byte is
//   presented on o_rx_data together with a one-clock o_valid pulse. A stop bit
//   sampled low gives a one-clock o_frame_err pulse instead. After a framing
//   error the receiver waits for the line to return high before it hunts for
//   the next start bit.
//
// Ports
//   i_clk        system clock, all logic on the rising edge
//   i_rst        synchronous, active-high reset
//   i_rxen       oversample tick, one clock wide, OSR ticks per bit period
//   i_rxd        asynchronous serial input, idle high
//   o_rx_data    last correctly framed byte, held until the next o_valid
//   o_valid      one-clock pulse, o_rx_data updated in the same cycle
//   o_frame_err  one-clock pulse, stop bit sampled as 0
//   o_busy       high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_os #(
  parameter int OSR   = 16,
  parameter int CNT_W = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxen,
  input  logic       i_rxd,
  output logic [7:0] o_rx_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Tick counts at which the start bit (half a bit in) and every later bit
  // (one full bit on from the previous sample) are sampled.
  localparam logic [CNT_W-1:0] TICK_MID = CNT_W'(OSR / 2 - 1);
  localparam logic [CNT_W-1:0] TICK_END = CNT_W'(OSR - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             w_rxd_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_tick_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_busy;

  assign w_rxd_s     = r_sync2;
  assign o_rx_data   = r_rx_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_busy      = r_busy;

  // Two-flop synchroniser for the asynchronous serial line; resets to idle-high
  // so that leaving reset never looks like a start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Receive state machine: start hunt, mid-bit sampling, stop check, pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= {CNT_W{1'b0}};
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_rx_data   <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Pulses are single-cycle: cleared every clock unless set below.
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      if (i_rxen) begin
        case (r_state)
          S_IDLE: begin
            if (!w_rxd_s) begin
              r_state    <= S_START;
              r_tick_cnt <= {CNT_W{1'b0}};
              r_busy     <= 1'b1;
            end
          end

          S_START: begin
            if (r_tick_cnt == TICK_MID) begin
              r_tick_cnt <= {CNT_W{1'b0}};
              if (!w_rxd_s) begin
                r_state   <= S_DATA;
                r_bit_cnt <= 3'd0;
              end else begin
                // Line went back high before mid start bit: treat as glitch.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            end
          end

          S_DATA: begin
            if (r_tick_cnt == TICK_END) begin
              r_tick_cnt <= {CNT_W{1'b0}};
              r_shift    <= {w_rxd_s, r_shift[7:1]};
              if (r_bit_cnt == 3'd7) begin
                r_state <= S_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            end
          end

          S_STOP: begin
            if (r_tick_cnt == TICK_END) begin
              r_tick_cnt <= {CNT_W{1'b0}};
              if (w_rxd_s) begin
                r_rx_data <= r_shift;
                r_valid   <= 1'b1;
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
              end else begin
                // Keep the old byte; wait for the line to recover so a held-low
                // line is not decoded as a stream of 0x00 frames.
                r_frame_err <= 1'b1;
                r_state     <= S_BREAK;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            end
          end

          S_BREAK: begin
            if (w_rxd_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end

          default: begin
            r_state    <= S_IDLE;
            r_tick_cnt <= {CNT_W{1'b0}};
            r_bit_cnt  <= 3'd0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
